uart_rx_fifo: RTL

//   Receive buffer directly downstream of the UART RX shift stage. Captures each

---
 rtl/uart_rx_fifo.sv | 68 ++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO behind the UART RX shift stage: one write per rx_done rising edge,
// sticky overrun when a byte arrives while full, registered IRQ, no input-to-output comb path.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done,
  input  logic [DATA_W-1:0]        rx_byte,
  input  logic                     rd_en,
  input  logic                     clr_overrun,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     rx_irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              wr_req;
  logic              rd_req;
  logic              wr_acc;

  assign wr_req = rx_done & ~done_q;
  assign rd_req = rd_en & ~empty;
  // When full, a same-cycle pop frees the slot the new byte lands in.
  assign wr_acc = wr_req & (~full | rd_req);

  assign count   = cnt_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b1;
      overrun <= 1'b0;
      rx_irq  <= 1'b0;
    end else begin
      done_q <= rx_done;
      rx_irq <= ~empty;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_req) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_req)      cnt_q <= cnt_q + 1'b1;
      else if (rd_req && !wr_acc) cnt_q <= cnt_q - 1'b1;
      // A new drop outranks a clear so no overrun event is ever lost.
      if (wr_req && full && !rd_req) overrun <= 1'b1;
      else if (clr_overrun)          overrun <= 1'b0;
    end
  end

endmodule
